// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline-stage register with valid/ready handshake, 2-entry skid buffer and flush.
// Invalid slots always present an all-zero payload, so a zero instruction word reads as a NOP.
module pipe_stage_skid #(
    parameter int FIELD_W    = 32,
    parameter int NUM_FIELDS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [FIELD_W*NUM_FIELDS-1:0] in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [FIELD_W*NUM_FIELDS-1:0] out_data,
    input  logic                          flush,
    output logic [1:0]                    occupancy
);

    localparam int PW = FIELD_W * NUM_FIELDS;

    // State bits are {main_v, skid_v}; the (0,1) code cannot be reached.
    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        ILLEGAL = 2'b01,
        ONE     = 2'b10,
        TWO     = 2'b11
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] main_d, main_n;
    logic [PW-1:0] skid_d, skid_n;
    logic          main_v, skid_v;
    logic          acc, dep;

    assign main_v    = state[1];
    assign skid_v    = state[0];
    assign in_ready  = !skid_v;
    assign out_valid = main_v;
    assign out_data  = main_d;
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

    assign acc = in_valid & in_ready;
    assign dep = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= EMPTY;
            main_d <= '0;
            skid_d <= '0;
        end else begin
            state  <= state_n;
            main_d <= main_n;
            skid_d <= skid_n;
        end
    end

    // in_data is only ever selected under acc, so an undriven bus stays out of the registers.
    always_comb begin
        state_n = state;
        main_n  = main_d;
        skid_n  = skid_d;
        if (flush) begin
            state_n = EMPTY;
            main_n  = '0;
            skid_n  = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        state_n = ONE;
                        main_n  = in_data;
                    end
                end
                ONE: begin
                    if (acc && dep) begin
                        main_n = in_data;
                    end else if (acc) begin
                        state_n = TWO;
                        skid_n  = in_data;
                    end else if (dep) begin
                        state_n = EMPTY;
                        main_n  = '0;
                    end
                end
                TWO: begin
                    if (dep) begin
                        state_n = ONE;
                        main_n  = skid_d;
                        skid_n  = '0;
                    end
                end
                default: begin
                    state_n = EMPTY;
                    main_n  = '0;
                    skid_n  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table on the default and two sweep configurations,
// hand-written async-reset sequence, and a scoreboarded random handshake run on an 8x3 instance.
module tb_pipe_stage_skid;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Default 32x4 instance plus two sweep instances driven by the same handshake.
    logic         in_valid, out_ready, flush;
    logic [127:0] in_data;
    logic         in_ready, out_valid;
    logic [127:0] out_data;
    logic [1:0]   occupancy;

    logic         in_ready_s, out_valid_s;
    logic [0:0]   out_data_s;
    logic [1:0]   occupancy_s;
    logic [0:0]   in_data_s;

    logic         in_ready_w, out_valid_w;
    logic [383:0] out_data_w;
    logic [1:0]   occupancy_w;
    logic [383:0] in_data_w;

    assign in_data_s = in_data[0:0];
    assign in_data_w = {in_data, in_data, in_data};

    // Random-run instance (FIELD_W=8, NUM_FIELDS=3).
    logic        r_in_valid, r_out_ready, r_flush;
    logic [23:0] r_in_data;
    logic        r_in_ready, r_out_valid;
    logic [23:0] r_out_data;
    logic [1:0]  r_occupancy;

    pipe_stage_skid #(.FIELD_W(32), .NUM_FIELDS(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush(flush), .occupancy(occupancy)
    );

    pipe_stage_skid #(.FIELD_W(1), .NUM_FIELDS(1)) dut_s (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data_s),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .flush(flush), .occupancy(occupancy_s)
    );

    pipe_stage_skid #(.FIELD_W(64), .NUM_FIELDS(6)) dut_w (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data_w),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
        .flush(flush), .occupancy(occupancy_w)
    );

    pipe_stage_skid #(.FIELD_W(8), .NUM_FIELDS(3)) dut_r (
        .clk(clk), .reset(reset),
        .in_valid(r_in_valid), .in_ready(r_in_ready), .in_data(r_in_data),
        .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data),
        .flush(r_flush), .occupancy(r_occupancy)
    );

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] f0;
        logic        ev;
        logic [31:0] ef0;
        logic        erdy;
        logic [1:0]  eocc;
    } vec_t;

    localparam int NVEC = 17;
    vec_t tbl [NVEC];

    // Spread field0 into distinct patterns in every field so field placement is exercised.
    function automatic logic [127:0] mk(input logic [31:0] f0);
        return {~f0, f0 ^ 32'hA5A5_5A5A, f0 << 4, f0};
    endfunction

    task automatic checkOutput(input string name, input logic [383:0] act, input logic [383:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        in_valid  = v.iv;
        out_ready = v.ordy;
        flush     = v.fl;
        in_data   = mk(v.f0);
    endtask

    task automatic checkRow(input int i, input vec_t v);
        logic [127:0] exp_d;
        exp_d = v.ev ? mk(v.ef0) : 128'd0;
        checkOutput($sformatf("row%0d_valid", i), 384'(out_valid), 384'(v.ev));
        checkOutput($sformatf("row%0d_data", i), 384'(out_data), 384'(exp_d));
        checkOutput($sformatf("row%0d_ready", i), 384'(in_ready), 384'(v.erdy));
        checkOutput($sformatf("row%0d_occ", i), 384'(occupancy), 384'(v.eocc));
        checkOutput($sformatf("row%0d_s_valid", i), 384'(out_valid_s), 384'(v.ev));
        checkOutput($sformatf("row%0d_s_data", i), 384'(out_data_s), 384'(exp_d[0]));
        checkOutput($sformatf("row%0d_w_data", i), out_data_w, {exp_d, exp_d, exp_d});
        checkOutput($sformatf("row%0d_w_occ", i), 384'(occupancy_w), 384'(v.eocc));
    endtask

    logic [23:0] sb [$];
    logic [23:0] exp_r;

    initial begin
        // Stream 1..4 with out_ready high, then drain.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h1,  1'b1, 32'h1,  1'b1, 2'd1};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h2,  1'b1, 32'h2,  1'b1, 2'd1};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h3,  1'b1, 32'h3,  1'b1, 2'd1};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h4,  1'b1, 32'h4,  1'b1, 2'd1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 2'd0};
        // Stall absorbs A and B, refuses C, then releases A, B, C in order.
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h11, 1'b1, 32'h11, 1'b1, 2'd1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h22, 1'b1, 32'h11, 1'b0, 2'd2};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h33, 1'b1, 32'h11, 1'b0, 2'd2};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h33, 1'b1, 32'h22, 1'b1, 2'd1};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h33, 1'b1, 32'h33, 1'b1, 2'd1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 2'd0};
        // Flush in TWO with an offer, then flush in ONE with an accepted-looking offer.
        tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h44, 1'b1, 32'h44, 1'b1, 2'd1};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h55, 1'b1, 32'h44, 1'b0, 2'd2};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 32'h66, 1'b0, 32'h0,  1'b1, 2'd0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 32'h77, 1'b1, 32'h77, 1'b1, 2'd1};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 32'h88, 1'b0, 32'h0,  1'b1, 2'd0};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 2'd0};

        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
        r_in_valid = 1'b0; r_out_ready = 1'b0; r_flush = 1'b0; r_in_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_valid", 384'(out_valid), 384'(1'b0));
        checkOutput("reset_data", 384'(out_data), 384'd0);
        checkOutput("reset_ready", 384'(in_ready), 384'(1'b1));
        checkOutput("reset_occ", 384'(occupancy), 384'(2'd0));

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            applyStimulus(tbl[i]);
            @(posedge clk);
            #1;
            checkRow(i, tbl[i]);
        end

        // Fill to two entries, then hit reset between edges.
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0; in_data = mk(32'hA1);
        @(negedge clk);
        in_data = mk(32'hA2);
        @(posedge clk);
        #1;
        checkOutput("pre_reset_occ", 384'(occupancy), 384'(2'd2));
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_valid", 384'(out_valid), 384'(1'b0));
        checkOutput("async_reset_data", 384'(out_data), 384'd0);
        checkOutput("async_reset_occ", 384'(occupancy), 384'(2'd0));
        checkOutput("async_reset_ready", 384'(in_ready), 384'(1'b1));
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1; in_data = mk(32'hDEAD);
        @(posedge clk);
        #1;
        checkOutput("dead_valid", 384'(out_valid), 384'(1'b1));
        checkOutput("dead_data", 384'(out_data), 384'(mk(32'hDEAD)));
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("dead_drain_valid", 384'(out_valid), 384'(1'b0));
        checkOutput("dead_drain_data", 384'(out_data), 384'd0);

        // Random handshake against a queue model on the 8x3 instance.
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            r_in_valid  = 1'($urandom_range(0, 1));
            r_out_ready = 1'($urandom_range(0, 1));
            r_flush     = ($urandom_range(0, 99) < 2);
            r_in_data   = 24'($urandom);
            #1;
            checkOutput("rnd_occ", 384'(r_occupancy), 384'(sb.size()));
            checkOutput("rnd_ready", 384'(r_in_ready), 384'(sb.size() < 2));
            if (sb.size() == 0) begin
                checkOutput("rnd_idle_valid", 384'(r_out_valid), 384'(1'b0));
                checkOutput("rnd_idle_data", 384'(r_out_data), 384'd0);
            end else begin
                exp_r = sb[0];
                checkOutput("rnd_valid", 384'(r_out_valid), 384'(1'b1));
                checkOutput("rnd_data", 384'(r_out_data), 384'(exp_r));
                if (r_out_ready)
                    void'(sb.pop_front());
            end
            if (r_flush)
                sb.delete();
            else if (r_in_valid && r_in_ready)
                sb.push_back(r_in_data);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic, parametrised pipeline-stage register that replaces the fixed per-stage latches (ID/EX, EX/MEM, MEM/WB).
- Carries NUM_FIELDS packed payload fields of FIELD_W bits each, for example IR, RD2, PC and ALU result.
- Adds a valid/ready handshake, a 2-entry skid buffer for full throughput under backpressure, and synchronous flush for bubble insertion.
- Sits between two pipeline stages. Invalid slots present an all-zero payload, so IR=0 acts as a NOP downstream.

Parameters:
FIELD_W, 32, width of one payload field
NUM_FIELDS, 4, number of payload fields; total payload width PW = FIELD_W*NUM_FIELDS

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  upstream presents a valid payload
in_ready  output  1  stage can accept a payload this cycle
in_data  input  PW  upstream payload; field k occupies bits [k*FIELD_W +: FIELD_W]
out_valid  output  1  out_data holds a valid payload
out_ready  input  1  downstream accepts; out_ready=0 is a stall
out_data  output  PW  payload from the main register; all-zero when out_valid=0
flush  input  1  synchronous kill of all held entries
occupancy  output  2  number of held entries: 0, 1 or 2

Behaviour:
- Storage is a main register (main_v, main_d) and a skid register (skid_v, skid_d).
  - out_valid = main_v; out_data = main_d.
  - in_ready = !skid_v, taken combinationally from state only; in_ready never depends on out_ready.
  - occupancy = main_v + skid_v.
- Transfer events:
  - acc = in_valid & in_ready
  - dep = out_valid & out_ready
- Reset is asynchronous and applies immediately:
  - main_v=0, skid_v=0, main_d=0, skid_d=0.
  - Outputs during and after reset: out_valid=0, out_data=0, in_ready=1, occupancy=0.
  - Reset mid-operation discards all held entries with no partial state.
- States are encoded by (main_v, skid_v):
  - EMPTY (0,0): on acc -> ONE, main_d<=in_data. Otherwise hold.
  - ONE (1,0):
    - acc&dep -> ONE, main_d<=in_data.
    - acc only -> TWO, skid_d<=in_data; main is held.
    - dep only -> EMPTY, main_d<=0.
    - neither -> hold.
  - TWO (1,1): in_ready=0, so acc cannot occur.
    - dep -> ONE, main_d<=skid_d, skid_d<=0.
    - Otherwise hold.
  - (0,1) is illegal and unreachable; if ever decoded, the next state is EMPTY.
- Flush is sampled at the rising edge and has priority over every transfer:
  - Next state is EMPTY, main_d=0, skid_d=0.
  - A dep in the flush cycle still counts as delivered downstream.
  - An acc in the flush cycle is discarded.
  - in_ready=1 on the following cycle.
- Ordering: payloads leave in strict acceptance order. No payload is duplicated or dropped except by flush or reset.
- Latency: 1 cycle from acc (in EMPTY) to out_valid=1. Throughput is 1 payload/cycle while out_ready=1.
- Backpressure:
  - With out_ready held low, at most 2 payloads are absorbed.
  - in_ready deasserts the cycle after the second acc.
  - Payload contents are held bit-stable while out_valid=1 and out_ready=0.
- Width rule: payload is passed bit-exact with no arithmetic. Zeroing applies to the whole PW vector.
- in_data is ignored when acc=0. X on in_data with in_valid=0 must not propagate into the registers.

Test Plan:
- Reset then stream: reset=1 for 2 cycles, then in_valid=1 with in_data field0 = 1,2,3,4 on consecutive cycles, out_ready=1.
  - Required: out_valid rises 1 cycle after the first acc; out_data field0 = 1,2,3,4 on consecutive cycles; in_ready stays 1; occupancy=1.
- Stall absorb: out_ready=0, offer A=0x11, B=0x22, C=0x33.
  - Required: A and B accepted; in_ready=0 after B; occupancy=2; out_data=A held stable; C not accepted.
  - Then out_ready=1: outputs A, B, C in order; occupancy returns to 1 then 0 once input stops.
- Flush in TWO with simultaneous offer: flush=1 while in_valid=1.
  - Required: next cycle out_valid=0, out_data=0, occupancy=0, in_ready=1; the offered payload never appears at the output.
- Asynchronous reset mid-stream: assert reset between clock edges while occupancy=2.
  - Required: out_valid=0, out_data=0 and occupancy=0 immediately, before the next edge; after deassert, a new payload 0xDEAD appears 1 cycle after acc.
- Random handshake: 10k cycles of random in_valid/out_ready/flush (flush 2%), NUM_FIELDS=3, FIELD_W=8.
  - Required: a scoreboard confirms in-order, lossless delivery between flushes; occupancy never exceeds 2; out_data=0 whenever out_valid=0.
- Parameter sweep: repeat scenario 1 with FIELD_W=1, NUM_FIELDS=1, and with FIELD_W=64, NUM_FIELDS=6.
  - Required: bit-exact payloads in both configurations.
